// File: rtl/subbytes_seq.sv
// Sequential AES SubBytes: LANES S-box lookups per cycle over a captured 128-bit state.
// Optional inverse S-box selected per transaction when SUBBYTES_INV_EN is defined (adds port inv_i).
module subbytes_seq #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_state_i,
`ifdef SUBBYTES_INV_EN
    input  logic         inv_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_state_o,
    output logic         busy_o
);

    localparam int unsigned Steps = 16 / LANES;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] FwdTab = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUBBYTES_INV_EN
    localparam logic [2047:0] InvTab = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };
`endif

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
`ifdef SUBBYTES_INV_EN
    logic            inv_q, inv_d;
`endif

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
`ifdef SUBBYTES_INV_EN
        if (inv) return InvTab[2047 - 8 * int'(b) -: 8];
`endif
        return FwdTab[2047 - 8 * int'(b) -: 8];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
`ifdef SUBBYTES_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    work_d  = in_state_i;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SUBBYTES_INV_EN
                    inv_d   = inv_i;
`endif
                end
            end
            StRun: begin
                for (int l = 0; l < int'(LANES); l++) begin
`ifdef SUBBYTES_INV_EN
                    work_d[8 * (int'(cnt_q) * int'(LANES) + l) +: 8] =
                        sub_byte(work_q[8 * (int'(cnt_q) * int'(LANES) + l) +: 8], inv_q);
`else
                    work_d[8 * (int'(cnt_q) * int'(LANES) + l) +: 8] =
                        sub_byte(work_q[8 * (int'(cnt_q) * int'(LANES) + l) +: 8], 1'b0);
`endif
                end
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_valid_o && out_ready_i) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
`ifdef SUBBYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef SUBBYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign in_ready_o = (state_q == StIdle);
    assign busy_o     = (state_q == StRun) || (state_q == StDone);

    if (OUT_REG != 0) begin : g_out_reg
        logic         out_valid_q;
        logic [127:0] out_state_q;

        // Snapshot on the first DONE cycle; valid rises one cycle later and clears on handoff.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_state_q <= '0;
            end else begin
                out_valid_q <= (state_q == StDone) && !(out_valid_q && out_ready_i);
                if ((state_q == StDone) && !out_valid_q) out_state_q <= work_q;
            end
        end

        assign out_valid_o = out_valid_q;
        assign out_state_o = out_state_q;
    end else begin : g_out_comb
        assign out_valid_o = (state_q == StDone);
        assign out_state_o = work_q;
    end

endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: S-box reference derived from GF(2^8) inversion plus affine map.
module tb_subbytes_seq;

    localparam int unsigned LN  [6] = '{1, 2, 4, 8, 16, 4};
    localparam int unsigned ORG [6] = '{1, 1, 1, 1, 1, 0};
    localparam int          EXP_LAT [6] = '{17, 9, 5, 3, 2, 4};
    localparam int          P = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         inv;
    logic         ir [6];
    logic         ov [6];
    logic         bz [6];
    logic [127:0] os [6];

    for (genvar g = 0; g < 6; g++) begin : g_dut
        subbytes_seq #(
            .LANES   (LN[g]),
            .OUT_REG (ORG[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (in_valid),
            .in_ready_o  (ir[g]),
            .in_state_i  (in_state),
`ifdef SUBBYTES_INV_EN
            .inv_i       (inv),
`endif
            .out_valid_o (ov[g]),
            .out_ready_i (out_ready),
            .out_state_o (os[g]),
            .busy_o      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    typedef struct {
        logic [127:0] din;
        logic         iv;
        logic [127:0] dexp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = iv ? inv_m[s[8*k +: 8]] : fwd_m[s[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer s until the primary instance accepts; return its result and accept->valid latency.
    task automatic run_one(input logic [127:0] s, input logic iv, output logic [127:0] res,
                           output int lat);
        int n = 0;
        in_state = s;
        inv      = iv;
        in_valid = 1'b1;
        while (!ir[P] && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!ov[P] && lat < 50) begin
            tick();
            lat++;
        end
        res = os[P];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res, exp_s, s;
        logic [127:0] bytes_k;
        logic [127:0] fwd_k;
        logic [7:0]   y;
        logic         iv;
        int           lat;
        int           lats [6];
        logic [127:0] rs [6];

        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int c = 1; c < 256; c++) if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            fwd_m[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);

        bytes_k = 128'h0f0e0d0c0b0a09080706050403020100;
        fwd_k   = 128'h76abd7fe2b670130c56f6bf27b777c63;
        vecs.push_back('{bytes_k, 1'b0, fwd_k});
        vecs.push_back('{{16{8'h00}}, 1'b0, {16{8'h63}}});
        vecs.push_back('{{16{8'hff}}, 1'b0, {16{8'h16}}});
        vecs.push_back('{{16{8'h53}}, 1'b0, {16{8'hed}}});
`ifdef SUBBYTES_INV_EN
        vecs.push_back('{fwd_k, 1'b1, bytes_k});
        vecs.push_back('{bytes_k, 1'b0, fwd_k});
        vecs.push_back('{{16{8'h63}}, 1'b1, {16{8'h00}}});
        vecs.push_back('{{8{16'hed16}}, 1'b1, {8{16'h53ff}}});
`endif

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0; inv = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("reset_flags", {ov[P], ir[P], bz[P]}, 3'b010);
        chk("reset_out_state", os[P], '0);
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_one(vecs[i].din, vecs[i].iv, res, lat);
            chk($sformatf("table%0d", i), res, vecs[i].dexp);
            chk($sformatf("table%0d_lat", i), lat, 5);
        end

        // Byte sweep: every S-box input appears once across lanes.
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(16 * t + k);
            run_one(s, 1'b0, res, lat);
            chk($sformatf("sweep%0d", t), res, model(s, 1'b0));
        end

        for (int t = 0; t < 24; t++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUBBYTES_INV_EN
            iv = 1'($urandom_range(0, 1));
`else
            iv = 1'b0;
`endif
            run_one(s, iv, res, lat);
            chk($sformatf("rand%0d", t), res, model(s, iv));
            chk($sformatf("rand%0d_lat", t), lat, 5);
        end

        // Backpressure: result and flags frozen while out_ready is low.
        tick();
        out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        run_one(s, 1'b0, res, lat);
        exp_s = model(s, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp_state%0d", c), os[P], exp_s);
            chk($sformatf("bp_flags%0d", c), {ov[P], ir[P], bz[P]}, 3'b101);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", {ov[P], ir[P], bz[P]}, 3'b010);

        // Reset while RUN with cnt=2.
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", {ov[P], ir[P], bz[P]}, 3'b001);
        rst = 1'b1;
        #1;
        chk("rst_run_flags", {ov[P], ir[P], bz[P]}, 3'b010);
        tick();
        rst = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        run_one(s, 1'b0, res, lat);
        chk("after_rst", res, model(s, 1'b0));
        chk("after_rst_lat", lat, 5);

        // Reset while DONE under backpressure: out_valid drops without a clock.
        tick();
        out_ready = 1'b0;
        run_one(s, 1'b0, res, lat);
        #2 rst = 1'b1;
        #1;
        chk("rst_done_flags", {ov[P], ir[P], bz[P]}, 3'b010);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // All lane widths and the unregistered-output variant from a common accept edge.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_state = bytes_k;
        inv = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < 6; g++) begin
            lats[g] = 0;
            rs[g] = '0;
        end
        for (int n = 1; n <= 25; n++) begin
            tick();
            for (int g = 0; g < 6; g++) begin
                if (ov[g] && lats[g] == 0) begin
                    lats[g] = n;
                    rs[g] = os[g];
                end
            end
        end
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("lanes%0d_or%0d_lat", LN[g], ORG[g]), lats[g], EXP_LAT[g]);
            chk($sformatf("lanes%0d_or%0d_state", LN[g], ORG[g]), rs[g], fwd_k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
